// File: rtl/snake_pkg.sv
// snake_pkg: shared types for the snake movement engine
//   direction    - steering encoding produced by the mouse stage
//   body_state_t - step sequencer states of snake_body
package snake_pkg;
    typedef enum logic [2:0] {STAY = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} direction;
    typedef enum logic [2:0] {IDLE, MOVE, SCAN, COMMIT, DEAD} body_state_t;
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: one-cell toroidal step of a grid position
//   x, y   in  current cell
//   dir    in  step direction; any non-cardinal encoding holds position
//   nx, ny out wrapped neighbour cell
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    localparam int X_W = $clog2(GRID_W),
    localparam int Y_W = $clog2(GRID_H)
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  direction       dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny
);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
    always_comb begin
        nx = dir == LEFT ? (x == '0 ? X_MAX : x - X_ONE) : dir == RIGHT ? (x == X_MAX ? '0 : x + X_ONE) : x;
        ny = dir == UP ? (y == '0 ? Y_MAX : y - Y_ONE) : dir == DOWN ? (y == Y_MAX ? '0 : y + Y_ONE) : y;
    end
endmodule

// File: rtl/snake_body.sv
// snake_body: game-tick movement engine with circular body buffer and self-collision detection
//   clk, rst           clock and asynchronous active-high reset
//   clk_divided        game tick clock, rising edge detected in the clk domain
//   dir                steering input, latched on the tick
//   grow               pulse requesting one extra segment on the next step
//   seg_idx            read index (0 = head) -> seg_x, seg_y, seg_valid
//   head_x, head_y     current head cell
//   length             current segment count
//   alive              cleared (sticky) on self-collision
//   step_done          one-cycle pulse when a step has been committed
module snake_body
    import snake_pkg::*;
#(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int MAX_LEN   = 64,
    parameter int START_X   = 16,
    parameter int START_Y   = 12,
    parameter int START_LEN = 3,
    localparam int X_W = $clog2(GRID_W),
    localparam int Y_W = $clog2(GRID_H),
    localparam int P_W = $clog2(MAX_LEN),
    localparam int L_W = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_divided,
    input  direction       dir,
    input  logic           grow,
    input  logic [P_W-1:0] seg_idx,
    output logic [X_W-1:0] seg_x,
    output logic [Y_W-1:0] seg_y,
    output logic           seg_valid,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [L_W-1:0] length,
    output logic           alive,
    output logic           step_done
);
    localparam logic [L_W-1:0] L_ONE = L_W'(1);
    logic [X_W-1:0] body_x [MAX_LEN];
    logic [Y_W-1:0] body_y [MAX_LEN];
    body_state_t    state;
    direction       dir_q;
    logic [P_W-1:0] head_ptr, ptr_nxt, scan_idx, seg_ptr;
    logic [L_W-1:0] scan_len, cnt;
    logic [X_W-1:0] nxt_x, step_x;
    logic [Y_W-1:0] nxt_y, step_y;
    logic           clk_div_prev, grow_pend, tick, hit;

    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next (
        .x  (head_x),
        .y  (head_y),
        .dir(dir_q),
        .nx (step_x),
        .ny (step_y)
    );

    assign tick      = !clk_div_prev && clk_divided;
    assign ptr_nxt   = head_ptr + P_W'(1);
    // Walk backwards from the head; pointer arithmetic wraps mod MAX_LEN.
    assign scan_idx  = head_ptr - P_W'(cnt);
    assign seg_ptr   = head_ptr - seg_idx;
    assign hit       = nxt_x == body_x[scan_idx] && nxt_y == body_y[scan_idx];
    assign seg_x     = body_x[seg_ptr];
    assign seg_y     = body_y[seg_ptr];
    assign seg_valid = L_W'(seg_idx) < length;
    assign head_x    = body_x[head_ptr];
    assign head_y    = body_y[head_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Body image: head at START_Y, remaining segments trail downward.
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x[i] <= i < START_LEN ? X_W'(START_X) : '0;
                body_y[i] <= i < START_LEN ? Y_W'(START_Y + START_LEN - 1 - i) : '0;
            end
            head_ptr     <= P_W'(START_LEN - 1);
            length       <= L_W'(START_LEN);
            alive        <= 1'b1;
            step_done    <= 1'b0;
            grow_pend    <= 1'b0;
            state        <= IDLE;
            dir_q        <= UP;
            clk_div_prev <= 1'b0;
            nxt_x        <= '0;
            nxt_y        <= '0;
            scan_len     <= '0;
            cnt          <= '0;
        end else begin
            clk_div_prev <= clk_divided;
            step_done    <= 1'b0;
            if (grow) grow_pend <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    dir_q <= dir;
                    state <= MOVE;
                end
                MOVE: begin
                    nxt_x    <= step_x;
                    nxt_y    <= step_y;
                    // Without growth the tail cell is vacated, so it is not scanned.
                    scan_len <= grow_pend ? length : length - L_ONE;
                    cnt      <= '0;
                    state    <= SCAN;
                end
                SCAN: if (hit) begin
                    alive <= 1'b0;
                    state <= DEAD;
                end else if (cnt == scan_len - L_ONE) begin
                    state <= COMMIT;
                end else begin
                    cnt <= cnt + L_ONE;
                end
                COMMIT: begin
                    head_ptr         <= ptr_nxt;
                    body_x[ptr_nxt]  <= nxt_x;
                    body_y[ptr_nxt]  <= nxt_y;
                    if (grow_pend && length < L_W'(MAX_LEN)) length <= length + L_ONE;
                    grow_pend        <= 1'b0;
                    step_done        <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= DEAD;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed self-checking bench for snake_body
module tb_snake_body;
    import snake_pkg::*;
    logic       clk = 1'b0, rst = 1'b1, clk_divided = 1'b0, grow = 1'b0;
    direction   dir = UP;
    logic [5:0] seg_idx = '0;
    logic [4:0] seg_x, seg_y, head_x, head_y;
    logic [6:0] length;
    logic       seg_valid, alive, step_done;
    int         checks = 0, failures = 0;
    int         lat, bad;
    bit         done, died;

    snake_body dut (
        .clk        (clk),
        .rst        (rst),
        .clk_divided(clk_divided),
        .dir        (dir),
        .grow       (grow),
        .seg_idx    (seg_idx),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .seg_valid  (seg_valid),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .alive      (alive),
        .step_done  (step_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Optional grow pulse, then one tick; returns cycles until step_done or death.
    // dir is scrambled after the tick cycle to show it is only sampled once.
    task automatic step(input direction d, input bit g, output int l, output bit dn, output bit dd);
        bit was_alive;
        if (g) begin
            @(negedge clk);
            grow = 1'b1;
            @(negedge clk);
            grow = 1'b0;
        end
        @(negedge clk);
        dir = d;
        clk_divided = 1'b1;
        was_alive = alive;
        l = 0;
        dn = 1'b0;
        dd = 1'b0;
        while (l < 100 && !dn && !dd) begin
            @(negedge clk);
            l++;
            clk_divided = 1'b0;
            dir = STAY;
            dn = step_done;
            dd = was_alive && !alive;
        end
    endtask

    task automatic chk_seg(input string tag, input logic [5:0] idx, input logic [4:0] ex, input logic [4:0] ey);
        seg_idx = idx;
        #1;
        chk({tag, "_x"}, seg_x, ex);
        chk({tag, "_y"}, seg_y, ey);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_head_x", head_x, 16);
        chk("rst_head_y", head_y, 12);
        chk("rst_length", length, 3);
        chk("rst_alive", alive, 1);
        chk("rst_step_done", step_done, 0);
        chk_seg("rst_seg1", 1, 16, 13);
        chk_seg("rst_seg2", 2, 16, 14);
        chk("rst_seg2_valid", seg_valid, 1);
        seg_idx = 3;
        #1;
        chk("rst_seg3_valid", seg_valid, 0);

        for (int k = 1; k <= 13; k++) begin
            step(UP, 1'b0, lat, done, died);
            chk("up_latency", lat, 5);
            if (k == 12) chk("up_y_zero", head_y, 0);
        end
        chk("up_wrap_x", head_x, 16);
        chk("up_wrap_y", head_y, 23);
        chk_seg("up_seg1", 1, 16, 0);
        chk_seg("up_seg2", 2, 16, 1);
        chk("up_length", length, 3);
        chk("up_alive", alive, 1);
        @(negedge clk);
        chk("step_done_pulse", step_done, 0);

        do_reset();
        step(RIGHT, 1'b1, lat, done, died);
        chk("grow_latency", lat, 6);
        chk("grow_head_x", head_x, 17);
        chk("grow_head_y", head_y, 12);
        chk("grow_length", length, 4);
        chk_seg("grow_seg1", 1, 16, 12);
        chk_seg("grow_tail", 3, 16, 14);
        bad = 0;
        for (int k = 1; k <= 61; k++) begin
            step((k == 24 || k == 48) ? RIGHT : UP, 1'b1, lat, done, died);
            if (!done) bad++;
            if (k == 60) chk("len_reach_max", length, 64);
        end
        chk("grow_steps_done", bad, 0);
        chk("sat_latency", lat, 67);
        chk("sat_length", length, 64);
        chk("sat_head_x", head_x, 19);
        chk("sat_head_y", head_y, 1);
        seg_idx = 63;
        #1;
        chk("sat_seg63_valid", seg_valid, 1);
        step(UP, 1'b0, lat, done, died);
        chk("full_nogrow_latency", lat, 66);
        chk("full_nogrow_length", length, 64);
        chk("full_nogrow_head_y", head_y, 0);

        do_reset();
        step(UP, 1'b1, lat, done, died);
        step(UP, 1'b1, lat, done, died);
        chk("len5_latency", lat, 7);
        chk("len5_length", length, 5);
        step(RIGHT, 1'b0, lat, done, died);
        chk("coil_right_done", done, 1);
        step(DOWN, 1'b0, lat, done, died);
        chk("coil_down_done", done, 1);
        step(LEFT, 1'b0, lat, done, died);
        chk("coll_died", died, 1);
        chk("coll_no_step_done", done, 0);
        chk("coll_latency", lat, 6);
        chk("coll_head_x", head_x, 17);
        chk("coll_head_y", head_y, 11);
        chk("coll_length", length, 5);
        step(UP, 1'b0, lat, done, died);
        chk("dead_tick_ignored", done, 0);
        chk("dead_head_y", head_y, 11);
        chk("dead_alive", alive, 0);

        do_reset();
        step(RIGHT, 1'b1, lat, done, died);
        step(DOWN, 1'b0, lat, done, died);
        chk("tail_down_latency", lat, 6);
        step(LEFT, 1'b0, lat, done, died);
        chk("tail_enter_done", done, 1);
        chk("tail_enter_alive", alive, 1);
        chk("tail_enter_x", head_x, 16);
        chk("tail_enter_y", head_y, 13);
        step(UP, 1'b0, lat, done, died);
        chk("tail_again_alive", alive, 1);
        chk("tail_again_y", head_y, 12);
        chk("tail_length", length, 4);

        do_reset();
        step(UP, 1'b0, lat, done, died);
        chk("pre_rst_head_y", head_y, 11);
        @(negedge clk);
        dir = UP;
        clk_divided = 1'b1;
        @(negedge clk);
        clk_divided = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midscan_rst_head_y", head_y, 12);
        chk("midscan_rst_length", length, 3);
        chk("midscan_rst_alive", alive, 1);
        chk_seg("midscan_rst_seg2", 2, 16, 14);
        @(negedge clk);
        rst = 1'b0;
        step(UP, 1'b0, lat, done, died);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_head_y", head_y, 11);
        step(direction'(3'd7), 1'b0, lat, done, died);
        chk("hold_dir_died", died, 1);
        chk("hold_dir_latency", lat, 3);
        chk("hold_dir_head_y", head_y, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
